// File: rtl/hls_kernel_run_sequencer.sv
// rtl/hls_kernel_run_sequencer.sv - ap_ctrl_chain batch run sequencer with latency statistics
//
// Runs one HLS kernel N times back to back on the ap_ctrl_chain handshake and
// records the start-to-done latency of every run (last, min, max).
//
// Optional watchdog: define HLS_RUN_SEQ_WATCHDOG_EN to enable the per-run
// timeout (parameter WDOG_CYCLES exists only in that build).
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   cmd_valid_i          batch command valid (accepted only while idle)
//   cmd_ready_o          high while idle
//   cmd_count_i          number of runs in the batch; 0 is legal
//   abort_i              level; batch stops after the run being acknowledged
//   ap_start_o           kernel start, held until ap_ready_i is sampled
//   ap_ready_i           kernel accepted its inputs
//   ap_done_i            kernel finished a run
//   ap_continue_o        one-cycle acknowledge of ap_done_i
//   busy_o               batch in progress
//   batch_done_o         one-cycle pulse at batch end
//   runs_done_o          completed runs in the current/last batch
//   lat_last_o           latency of the most recent run
//   lat_min_o/lat_max_o  min/max latency over the current/last batch
//   err_timeout_o        sticky watchdog error (constant 0 without the watchdog)

module hls_kernel_run_sequencer #(
    parameter int CNT_W = 16,
    parameter int LAT_W = 20
`ifdef HLS_RUN_SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 4096
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic             abort_i,
    output logic             ap_start_o,
    input  logic             ap_ready_i,
    input  logic             ap_done_i,
    output logic             ap_continue_o,
    output logic             busy_o,
    output logic             batch_done_o,
    output logic [CNT_W-1:0] runs_done_o,
    output logic [LAT_W-1:0] lat_last_o,
    output logic [LAT_W-1:0] lat_min_o,
    output logic [LAT_W-1:0] lat_max_o,
    output logic             err_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_ACK,
        S_FINISH
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] runs_done_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [LAT_W-1:0] lat_last_q;
    logic [LAT_W-1:0] lat_min_q;
    logic [LAT_W-1:0] lat_max_q;
    logic             ap_start_q;
    logic             ap_continue_q;
    logic             busy_q;
    logic             batch_done_q;

    logic [LAT_W-1:0] lat_cnt_d;
    logic             run_done_d;

`ifdef HLS_RUN_SEQ_WATCHDOG_EN
    localparam logic [LAT_W-1:0] WDOG_LIM = LAT_W'(WDOG_CYCLES);
    logic err_timeout_q;
`endif

    // Saturating increment: a stuck counter reports 2^LAT_W-1 rather than wrapping.
    assign lat_cnt_d = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);

    // The kernel may raise ap_ready and ap_done together, which skips WAIT_DONE.
    always_comb begin
        run_done_d = 1'b0;
        if (state_q == S_START) begin
            run_done_d = ap_ready_i & ap_done_i;
        end else if (state_q == S_WAIT_DONE) begin
            run_done_d = ap_done_i;
        end
    end

    // The latency counter holds the number of clock edges between the first
    // ap_start cycle and the cycle ap_done is sampled; it is not advanced on
    // the done edge itself, so ACK sees the finished value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            runs_done_q   <= '0;
            lat_cnt_q     <= '0;
            lat_last_q    <= '0;
            lat_min_q     <= '1;
            lat_max_q     <= '0;
            ap_start_q    <= 1'b0;
            ap_continue_q <= 1'b0;
            busy_q        <= 1'b0;
            batch_done_q  <= 1'b0;
`ifdef HLS_RUN_SEQ_WATCHDOG_EN
            err_timeout_q <= 1'b0;
`endif
        end else begin
            batch_done_q  <= 1'b0;
            ap_continue_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        remaining_q <= cmd_count_i;
                        runs_done_q <= '0;
                        lat_min_q   <= '1;
                        lat_max_q   <= '0;
                        busy_q      <= 1'b1;
                        if (cmd_count_i == '0) begin
                            state_q <= S_FINISH;
                        end else begin
                            state_q    <= S_START;
                            ap_start_q <= 1'b1;
                            lat_cnt_q  <= '0;
                        end
                    end
                end
                S_START, S_WAIT_DONE: begin
                    if (run_done_d) begin
                        ap_start_q    <= 1'b0;
                        ap_continue_q <= 1'b1;
                        state_q       <= S_ACK;
                    end
`ifdef HLS_RUN_SEQ_WATCHDOG_EN
                    else if (lat_cnt_q >= WDOG_LIM) begin
                        err_timeout_q <= 1'b1;
                        ap_start_q    <= 1'b0;
                        state_q       <= S_FINISH;
                    end
`endif
                    else begin
                        lat_cnt_q <= lat_cnt_d;
                        if (state_q == S_START && ap_ready_i) begin
                            ap_start_q <= 1'b0;
                            state_q    <= S_WAIT_DONE;
                        end
                    end
                end
                S_ACK: begin
                    lat_last_q <= lat_cnt_q;
                    if (lat_cnt_q < lat_min_q) begin
                        lat_min_q <= lat_cnt_q;
                    end
                    if (lat_cnt_q > lat_max_q) begin
                        lat_max_q <= lat_cnt_q;
                    end
                    runs_done_q <= runs_done_q + CNT_W'(1);
                    remaining_q <= remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1) || abort_i) begin
                        state_q <= S_FINISH;
                    end else begin
                        state_q    <= S_START;
                        ap_start_q <= 1'b1;
                        lat_cnt_q  <= '0;
                    end
                end
                S_FINISH: begin
                    batch_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign ap_start_o    = ap_start_q;
    assign ap_continue_o = ap_continue_q;
    assign busy_o        = busy_q;
    assign batch_done_o  = batch_done_q;
    assign runs_done_o   = runs_done_q;
    assign lat_last_o    = lat_last_q;
    assign lat_min_o     = lat_min_q;
    assign lat_max_o     = lat_max_q;
`ifdef HLS_RUN_SEQ_WATCHDOG_EN
    assign err_timeout_o = err_timeout_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_hls_kernel_run_sequencer.sv
// tb/tb_hls_kernel_run_sequencer.sv - self-checking bench for hls_kernel_run_sequencer

module tb_hls_kernel_run_sequencer;

    localparam int CW   = 16;
    localparam int LW   = 8;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_count;
    logic          abort;
    logic          ap_start;
    logic          ap_ready;
    logic          k_done;
    logic          stray_done;
    logic          ap_done;
    logic          ap_continue;
    logic          busy;
    logic          batch_done;
    logic [CW-1:0] runs_done;
    logic [LW-1:0] lat_last;
    logic [LW-1:0] lat_min;
    logic [LW-1:0] lat_max;
    logic          err_timeout;

    assign ap_done = k_done | stray_done;

    hls_kernel_run_sequencer #(
        .CNT_W(CW),
        .LAT_W(LW)
`ifdef HLS_RUN_SEQ_WATCHDOG_EN
        ,
        .WDOG_CYCLES(100)
`endif
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_count_i  (cmd_count),
        .abort_i      (abort),
        .ap_start_o   (ap_start),
        .ap_ready_i   (ap_ready),
        .ap_done_i    (ap_done),
        .ap_continue_o(ap_continue),
        .busy_o       (busy),
        .batch_done_o (batch_done),
        .runs_done_o  (runs_done),
        .lat_last_o   (lat_last),
        .lat_min_o    (lat_min),
        .lat_max_o    (lat_max),
        .err_timeout_o(err_timeout)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Kernel model: ap_ready one cycle after ap_start is first seen, ap_done
    // at cycle index cur_lat after that first start cycle, held until ap_continue.
    int lat_q[$];
    bit in_run = 0;
    int idx = 0;
    int cur_lat = 1;
    int run_no = 0;
    int abort_run = 0;
    int bd_cnt = 0;
    int ack_cnt = 0;
    int proto_err = 0;
    bit prev_start = 0;
    bit prev_ready = 0;

    task automatic kernel_step();
        if (!rst_ni) begin
            in_run = 0; ap_ready = 0; k_done = 0; prev_start = 0; prev_ready = 0;
            return;
        end
        if (batch_done) bd_cnt++;
        if (ap_continue) ack_cnt++;
        if (prev_start && !ap_start && !prev_ready) proto_err++;
        prev_start = ap_start;
        if (ap_continue) begin
            in_run = 0;
        end else begin
            if (!in_run && ap_start) begin
                in_run = 1; idx = 0; run_no++;
                if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
                else cur_lat = 1;
                if (run_no == abort_run) abort = 1;
            end else if (in_run) begin
                idx++;
            end
            ap_ready = in_run && (idx == 1);
            k_done   = in_run && (idx >= cur_lat) && (idx >= 1);
        end
        prev_ready = ap_ready;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            kernel_step();
        end
    end

    // Issues one batch and waits (bounded) for batch_done; k = cycles from the
    // command cycle to the batch_done cycle.
    task automatic run_batch(input int n, input int ab, input bit poke,
                             output int k, output int acks, output int bds);
        int a0;
        int b0;
        bit seen;
        a0 = ack_cnt; b0 = bd_cnt; seen = 0;
        run_no = 0; abort_run = ab;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_count = CW'(n);
        k = 0;
        while (!seen && k < 4000) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) cmd_valid = 0;
            if (poke && k == 5) begin
                chk("cmd_ready during run", cmd_ready, 0);
                cmd_valid = 1; cmd_count = 7;
            end
            if (poke && k == 6) cmd_valid = 0;
            if (batch_done) seen = 1;
        end
        chk("batch_done seen", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        abort = 0; abort_run = 0;
        acks = ack_cnt - a0;
        bds  = bd_cnt - b0;
    endtask

    typedef struct packed {
        int n;
        int l0; int l1; int l2; int l3; int l4;
        int ab;
        int poke;
        int e_runs; int e_last; int e_min; int e_max; int e_k;
    } vec_t;

    vec_t vecs [6];
    int   m_last = 0;

    task automatic check_batch(input int e_runs, input int e_last, input int e_min,
                               input int e_max, input int e_k, input int k,
                               input int acks, input int bds);
        chk("runs_done", runs_done, e_runs);
        chk("lat_last", lat_last, e_last);
        chk("lat_min", lat_min, e_min);
        chk("lat_max", lat_max, e_max);
        chk("batch_done latency", k, e_k);
        chk("ap_continue pulses", acks, e_runs);
        chk("batch_done pulses", bds, 1);
        chk("busy after batch", busy, 0);
        chk("cmd_ready after batch", cmd_ready, 1);
        chk("ap_start after batch", ap_start, 0);
        chk("err_timeout", err_timeout, 0);
    endtask

    initial begin
        int k;
        int acks;
        int bds;
        int lv[5];
        int n;
        int ab;
        int runs;
        int e_last;
        int e_min;
        int e_max;
        int e_k;
        int s;
        int b0;
        int a0;

        vecs[0] = '{3, 77, 77, 77, 0, 0, 0, 0, 3, 77, 77, 77, 239};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 77, 255, 0, 2};
        vecs[2] = '{2, 1, 1, 0, 0, 0, 0, 0, 2, 1, 1, 1, 8};
        vecs[3] = '{3, 10, 50, 30, 0, 0, 0, 1, 3, 30, 10, 50, 98};
        vecs[4] = '{5, 20, 25, 30, 35, 40, 2, 0, 2, 25, 20, 25, 51};
        vecs[5] = '{1, 300, 0, 0, 0, 0, 0, 0, 1, 255, 255, 255, 304};

        rst_ni = 0; cmd_valid = 0; cmd_count = '0; abort = 0;
        ap_ready = 0; k_done = 0; stray_done = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst ap_start", ap_start, 0);
        chk("rst ap_continue", ap_continue, 0);
        chk("rst busy", busy, 0);
        chk("rst batch_done", batch_done, 0);
        chk("rst runs_done", runs_done, 0);
        chk("rst lat_last", lat_last, 0);
        chk("rst lat_min", lat_min, LMAX);
        chk("rst lat_max", lat_max, 0);
        chk("rst err_timeout", err_timeout, 0);
        rst_ni = 1;

        // Stray ap_done while idle must not count as a run.
        @(posedge clk); #1;
        b0 = bd_cnt;
        stray_done = 1;
        repeat (3) @(posedge clk);
        #1;
        stray_done = 0;
        chk("stray done runs_done", runs_done, 0);
        chk("stray done cmd_ready", cmd_ready, 1);
        chk("stray done ap_continue", ack_cnt, 0);
        chk("stray done batch_done", bd_cnt - b0, 0);

        for (int v = 0; v < 6; v++) begin
            lv = '{vecs[v].l0, vecs[v].l1, vecs[v].l2, vecs[v].l3, vecs[v].l4};
            lat_q.delete();
            for (int i = 0; i < vecs[v].n; i++) lat_q.push_back(lv[i]);
            run_batch(vecs[v].n, vecs[v].ab, vecs[v].poke != 0, k, acks, bds);
            check_batch(vecs[v].e_runs, vecs[v].e_last, vecs[v].e_min,
                        vecs[v].e_max, vecs[v].e_k, k, acks, bds);
            m_last = vecs[v].e_last;
        end

        // Kernel that never finishes, then a reset in the middle of the run.
        lat_q.delete();
        lat_q.push_back(100000);
        a0 = ack_cnt; run_no = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_count = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
`ifdef HLS_RUN_SEQ_WATCHDOG_EN
        k = 0;
        while (!batch_done && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wdog batch_done", batch_done, 1);
        chk("wdog err_timeout", err_timeout, 1);
        chk("wdog runs_done", runs_done, 0);
        chk("wdog ap_start", ap_start, 0);
`else
        repeat (300) @(posedge clk);
        #1;
        chk("hang busy", busy, 1);
        chk("hang err_timeout", err_timeout, 0);
        chk("hang ap_continue", ack_cnt - a0, 0);
        chk("hang ap_start", ap_start, 0);
`endif
        rst_ni = 0;
        #1;
        chk("midrun rst busy", busy, 0);
        chk("midrun rst cmd_ready", cmd_ready, 1);
        chk("midrun rst ap_start", ap_start, 0);
        chk("midrun rst runs_done", runs_done, 0);
        chk("midrun rst lat_last", lat_last, 0);
        chk("midrun rst lat_min", lat_min, LMAX);
        chk("midrun rst err_timeout", err_timeout, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1;
        m_last = 0;

        // Randomized batches against the reference model.
        for (int it = 0; it < 8; it++) begin
            n  = $urandom_range(0, 5);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            for (int i = 0; i < 5; i++) lv[i] = $urandom_range(1, 60);
            runs = n;
            if (ab != 0 && ab < n) runs = ab;
            e_last = m_last; e_min = LMAX; e_max = 0; e_k = 2;
            for (int i = 0; i < runs; i++) begin
                s = (lv[i] > LMAX) ? LMAX : lv[i];
                e_last = s;
                if (s < e_min) e_min = s;
                if (s > e_max) e_max = s;
                e_k += lv[i] + 2;
            end
            m_last = e_last;
            lat_q.delete();
            for (int i = 0; i < n; i++) lat_q.push_back(lv[i]);
            run_batch(n, ab, 0, k, acks, bds);
            check_batch(runs, e_last, e_min, e_max, e_k, k, acks, bds);
        end

`ifndef HLS_RUN_SEQ_WATCHDOG_EN
        chk("ap_start dropped before ap_ready", proto_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hls_kernel_run_sequencer.md
Name: hls_kernel_run_sequencer

Overview:
- Drives the ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue) of one HLS kernel instance such as kp_502_7.
- Accepts a batch command of N back-to-back invocations, sequences each run and counts completions.
- Records per-run start-to-done latency: last, min, max.
- Sits between the host/testbench command interface and the kernel top; replaces a hand-driven ap_start in benches and integration.

Parameters:
- CNT_W, 16, width of batch count and completed-run counter.
- LAT_W, 20, width of latency counters; saturating.
- WDOG_CYCLES, 4096, watchdog limit in cycles per run; used only with the optional feature.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  batch command valid.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_count  in  CNT_W  number of runs; 0 is legal.
- abort  in  1  level; stop after the current run.
- ap_start  out  1  kernel start.
- ap_ready  in  1  kernel accepted inputs.
- ap_done  in  1  kernel finished a run.
- ap_continue  out  1  acknowledge of ap_done.
- busy  out  1  batch in progress.
- batch_done  out  1  one-cycle pulse at batch end.
- runs_done  out  CNT_W  completed runs in current/last batch.
- lat_last, lat_min, lat_max  out  LAT_W each  latency statistics.
- err_timeout  out  1  sticky watchdog error; stays 0 without the optional feature.

Behaviour:
- Reset values (reset low, asynchronous):
  - state IDLE; ap_start, ap_continue, busy, batch_done = 0.
  - runs_done = 0, lat_last = 0, lat_max = 0, lat_min = all-ones, err_timeout = 0.
- FSM states: IDLE, START, WAIT_DONE, ACK, FINISH.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_count into `remaining`; clear runs_done; set lat_min to all-ones and lat_max to 0; set busy = 1.
  - If cmd_count == 0, go to FINISH. Otherwise go to START.
- START:
  - ap_start = 1, held until the cycle ap_ready = 1 is sampled. Never deassert before ap_ready.
  - Latency counter cleared to 0 on entry to START, incremented every cycle while in START/WAIT_DONE.
  - On ap_ready & ~ap_done, go to WAIT_DONE.
  - On ap_ready & ap_done in the same cycle, go directly to ACK.
  - ap_start deasserts the cycle after ap_ready.
- WAIT_DONE: ap_start = 0; wait for ap_done, then go to ACK.
- ACK (one cycle):
  - ap_continue = 1.
  - lat_last = latency counter value including the done cycle.
  - Update lat_min/lat_max with unsigned compare; runs_done += 1; remaining -= 1.
  - If remaining becomes 0 or abort = 1, go to FINISH. Otherwise go to START (no idle gap).
- FINISH (one cycle): batch_done = 1, busy = 0, then go to IDLE.
- Latency arithmetic: counter saturates at 2^LAT_W-1 and does not wrap; a saturated value is reported as-is.
- abort:
  - Sampled only in ACK; never truncates a handshake in flight.
  - abort in IDLE is ignored; cmd_valid takes priority over abort.
- cmd_valid outside IDLE: ignored; cmd_ready = 0, no queueing.
- ap_done in START/IDLE/FINISH without a matching start: ignored (no counter change).
- Reset mid-run: all state returns to reset values immediately. The kernel must be reset concurrently; the sequencer does not re-synchronise.

Optional Feature:
- Macro: HLS_RUN_SEQ_WATCHDOG_EN.
- Defined:
  - If the latency counter reaches WDOG_CYCLES in START or WAIT_DONE, set err_timeout (sticky until reset).
  - Deassert ap_start and go to FINISH; batch_done still pulses; runs_done excludes the timed-out run.
- Undefined: no watchdog logic; err_timeout tied 0; sequencer waits indefinitely.

Test Plan:
- Reset, cmd_count=3, kernel model: ap_ready 1 cycle after start, ap_done 76 cycles later -> three ap_continue pulses, runs_done=3, lat_last=lat_min=lat_max=77, single batch_done pulse, busy low after.
- cmd_count=0 -> batch_done exactly 2 cycles after cmd_valid; ap_start never asserted; runs_done=0.
- Kernel asserts ap_ready and ap_done in the same cycle (latency 1 from start), cmd_count=2 -> lat_last=1, no WAIT_DONE visit, runs_done=2.
- Varying latencies 10, 50, 30 over cmd_count=3 -> lat_min=10, lat_max=50, lat_last=30.
- abort held high during run 2 of cmd_count=5 -> run 2 completes, runs_done=2, batch_done pulses, cmd_ready returns 1.
- With HLS_RUN_SEQ_WATCHDOG_EN, WDOG_CYCLES=100, kernel never asserts ap_done -> err_timeout=1 at cycle 100 after start, ap_start low, batch_done pulses, runs_done=0; without the macro, busy stays 1.
